// File: rtl/iter_div.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// go/done handshake with fixed latency: WIDTH cycles, or 1 cycle on a zero divisor.
module iter_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // ZDIV is a one-cycle slot that gives the zero-divisor result its unit latency.
  typedef enum logic [1:0] {IDLE, RUN, ZDIV, DONE} state_t;

  state_t          state_q;
  logic [WIDTH-1:0] dividend_q;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] rem_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             done_q;
  logic             busy_q;
  logic             dbz_q;

  logic [WIDTH:0]   remShift;
  logic [WIDTH:0]   trial;
  logic             geq;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;

  // The partial remainder never reaches the divisor, so the shifted value is below
  // 2*divisor: bit WIDTH of the single (WIDTH+1)-bit difference is the borrow.
  assign remShift = {rem_q, dividend_q[WIDTH-1]};
  assign trial    = remShift - {1'b0, divisor_q};
  assign geq      = ~trial[WIDTH];
  assign rem_d    = geq ? trial[WIDTH-1:0] : remShift[WIDTH-1:0];
  assign quo_d    = {dividend_q[WIDTH-2:0], geq};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      dividend_q  <= '0;
      divisor_q   <= '0;
      rem_q       <= '0;
      count_q     <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (go) begin
            dividend_q <= left;
            divisor_q  <= right;
            rem_q      <= '0;
            count_q    <= '0;
            if (right != '0) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end else begin
              state_q <= ZDIV;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        // Quotient bits shift into the dividend register as dividend bits leave it.
        RUN: begin
          rem_q      <= rem_d;
          dividend_q <= quo_d;
          count_q    <= count_q + CW'(1);
          if (count_q == LAST) begin
            quotient_q  <= quo_d;
            remainder_q <= rem_d;
            dbz_q       <= 1'b0;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= DONE;
          end
        end
        ZDIV: begin
          quotient_q  <= '1;
          remainder_q <= dividend_q;
          dbz_q       <= 1'b1;
          done_q      <= 1'b1;
          state_q     <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_iter_div.sv
// Directed and table-driven bench for iter_div at WIDTH=8, plus one WIDTH=32 case.
module tb_iter_div;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        go8, done8, busy8, dbz8;
  logic [7:0]  left8, right8, q8, r8;
  logic        go32, done32, busy32, dbz32;
  logic [31:0] left32, right32, q32, r32;

  int nChecks = 0;
  int nFails  = 0;

  logic [7:0] lastQ, lastR;
  logic       lastDbz;

  typedef struct {
    logic [7:0] l;
    logic [7:0] r;
    logic [7:0] q;
    logic [7:0] rm;
    logic       dbz;
  } vec_t;

  vec_t vecs[8];

  iter_div #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .go(go8), .left(left8), .right(right8),
    .quotient(q8), .remainder(r8), .done(done8), .busy(busy8), .div_by_zero(dbz8)
  );

  iter_div #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .go(go32), .left(left32), .right(right32),
    .quotient(q32), .remainder(r32), .done(done32), .busy(busy32), .div_by_zero(dbz32)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One full 8-bit transaction: go pulse, wait for done, check timing and results.
  task automatic applyStimulus(input logic [7:0] l, input logic [7:0] r,
                               input logic [7:0] eq, input logic [7:0] er,
                               input logic edbz, input string tag);
    int cyc;
    int busyCnt;
    bit held;
    @(negedge clk);
    go8 = 1'b1; left8 = l; right8 = r;
    @(negedge clk);
    go8 = 1'b0; left8 = 8'($urandom); right8 = 8'($urandom);
    cyc = 1; busyCnt = 0; held = 1'b1;
    while (!done8 && cyc < 64) begin
      if (busy8) busyCnt++;
      if (q8 !== lastQ || r8 !== lastR || dbz8 !== lastDbz) held = 1'b0;
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, " done"}, 64'(done8), 64'(1));
    checkOutput({tag, " latency"}, 64'(cyc - 1), edbz ? 64'(1) : 64'(8));
    checkOutput({tag, " busy cycles"}, 64'(busyCnt), edbz ? 64'(0) : 64'(8));
    checkOutput({tag, " outputs held"}, 64'(held), 64'(1));
    checkOutput({tag, " quotient"}, 64'(q8), 64'(eq));
    checkOutput({tag, " remainder"}, 64'(r8), 64'(er));
    checkOutput({tag, " div_by_zero"}, 64'(dbz8), 64'(edbz));
    @(negedge clk);
    checkOutput({tag, " done pulse width"}, 64'(done8), 64'(0));
    lastQ = eq; lastR = er; lastDbz = edbz;
  endtask

  initial begin
    int cyc;
    bit sawDone;
    logic [7:0] l, r, eq, er;
    logic [31:0] hq, hr;

    reset = 1'b1; go8 = 1'b0; left8 = '0; right8 = '0;
    go32 = 1'b0; left32 = '0; right32 = '0;
    lastQ = '0; lastR = '0; lastDbz = 1'b0;
    #12;
    checkOutput("reset quotient", 64'(q8), 64'(0));
    checkOutput("reset remainder", 64'(r8), 64'(0));
    checkOutput("reset done", 64'(done8), 64'(0));
    checkOutput("reset busy", 64'(busy8), 64'(0));
    checkOutput("reset div_by_zero", 64'(dbz8), 64'(0));
    checkOutput("reset quotient32", 64'(q32), 64'(0));
    @(negedge clk);
    reset = 1'b0;

    vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,  1'b0};
    vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0};
    vecs[2] = '{8'd5,   8'd9,   8'd0,   8'd5,  1'b0};
    vecs[3] = '{8'd255, 8'd255, 8'd1,   8'd0,  1'b0};
    vecs[4] = '{8'd42,  8'd0,   8'd255, 8'd42, 1'b1};
    vecs[5] = '{8'd200, 8'd10,  8'd20,  8'd0,  1'b0};
    vecs[6] = '{8'd0,   8'd5,   8'd0,   8'd0,  1'b0};
    vecs[7] = '{8'd1,   8'd255, 8'd0,   8'd1,  1'b0};
    for (int i = 0; i < 8; i++)
      applyStimulus(vecs[i].l, vecs[i].r, vecs[i].q, vecs[i].rm, vecs[i].dbz, $sformatf("vec%0d", i));

    // go held high throughout: only the DONE cycle may accept the second operands.
    @(negedge clk);
    go8 = 1'b1; left8 = 8'd100; right8 = 8'd7;
    @(negedge clk);
    cyc = 1;
    while (!done8 && cyc < 64) begin
      left8 = 8'($urandom); right8 = 8'($urandom);
      @(negedge clk);
      cyc++;
    end
    checkOutput("held-go first latency", 64'(cyc - 1), 64'(8));
    checkOutput("held-go first quotient", 64'(q8), 64'(14));
    checkOutput("held-go first remainder", 64'(r8), 64'(2));
    left8 = 8'd9; right8 = 8'd3;
    @(negedge clk);
    go8 = 1'b0;
    cyc = 1;
    while (!done8 && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("held-go second latency", 64'(cyc - 1), 64'(8));
    checkOutput("held-go second quotient", 64'(q8), 64'(3));
    checkOutput("held-go second remainder", 64'(r8), 64'(0));
    @(negedge clk);
    lastQ = 8'd3; lastR = 8'd0; lastDbz = 1'b0;

    // Asynchronous reset during the fourth RUN iteration.
    @(negedge clk);
    go8 = 1'b1; left8 = 8'd100; right8 = 8'd7;
    @(negedge clk);
    go8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("async reset quotient", 64'(q8), 64'(0));
    checkOutput("async reset busy", 64'(busy8), 64'(0));
    checkOutput("async reset done", 64'(done8), 64'(0));
    checkOutput("async reset div_by_zero", 64'(dbz8), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    sawDone = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done8) sawDone = 1'b1;
    end
    checkOutput("no done after abort", 64'(sawDone), 64'(0));
    lastQ = '0; lastR = '0; lastDbz = 1'b0;
    applyStimulus(8'd200, 8'd10, 8'd20, 8'd0, 1'b0, "post-reset");

    for (int i = 0; i < 1000; i++) begin
      l = 8'($urandom_range(0, 255));
      r = 8'($urandom_range(0, 255));
      eq = (r == 8'd0) ? 8'hFF : 8'(l / r);
      er = (r == 8'd0) ? l : 8'(l % r);
      applyStimulus(l, r, eq, er, (r == 8'd0), $sformatf("rand%0d %0d/%0d", i, l, r));
      if (r != 8'd0)
        checkOutput($sformatf("rand%0d invariant", i), 64'(int'(q8) * int'(r) + int'(r8)), 64'(l));
    end

    @(negedge clk);
    go32 = 1'b1; left32 = 32'hFFFF_FFFF; right32 = 32'h0001_0000;
    @(negedge clk);
    go32 = 1'b0; left32 = 32'h1234_5678; right32 = 32'd3;
    cyc = 1;
    while (!done32 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("w32 done", 64'(done32), 64'(1));
    checkOutput("w32 latency", 64'(cyc - 1), 64'(32));
    checkOutput("w32 quotient", 64'(q32), 64'(32'h0000_FFFF));
    checkOutput("w32 remainder", 64'(r32), 64'(32'h0000_FFFF));
    checkOutput("w32 div_by_zero", 64'(dbz32), 64'(0));
    hq = 32'h0000_FFFF; hr = 32'h0000_FFFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("w32 hold%0d quotient", i), 64'(q32), 64'(hq));
      checkOutput($sformatf("w32 hold%0d remainder", i), 64'(r32), 64'(hr));
      checkOutput($sformatf("w32 hold%0d done", i), 64'(done32), 64'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
